product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter ACC_W SHALL default to 24 and SHALL set the accumulator and result width (legal range 16..32).
REQ-003 Parameter LEN_W SHALL default to 4 and SHALL set the width of the run-length input.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  single-cycle request to begin a run; sampled only in IDLE.
REQ-007 len  input  LEN_W  number of products in the run, captured with start.
REQ-008 prod  input  16  signed two's-complement product from the upstream 8x8 Booth multiplier.
REQ-009 prod_valid  input  1  prod is valid this cycle.
REQ-010 prod_ready  output  1  block accepts prod this cycle.
REQ-011 res  output  ACC_W  signed accumulated result.
REQ-012 res_valid  output  1  res is valid and held.
REQ-013 res_ready  input  1  downstream consumes res this cycle.
REQ-014 sat  output  1  sticky flag: saturation occurred in the current or last run.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The block SHALL implement three states: IDLE, ACC and HOLD.
REQ-017 In IDLE, when start=1, the block SHALL capture len into a remaining counter, clear the accumulator to 0 and clear sat.
  - If len!=0, the next state SHALL be ACC.
  - If len=0, the next state SHALL be HOLD, with res=0.
REQ-018 In IDLE, when start=0, the block SHALL hold res and sat at their last values.
REQ-019 prod_ready SHALL be 1 only in ACC.
REQ-020 A product SHALL be accepted only on a cycle with prod_valid=1 and prod_ready=1.
  - Cycles with prod_valid=0 SHALL leave the accumulator and the counter unchanged.
REQ-021 On each accepted product, the accumulator SHALL update as follows.
  - Form the sum acc + sign-extended prod in ACC_W+1 bits.
  - On positive overflow, clamp to 2^(ACC_W-1)-1.
  - On negative overflow, clamp to -2^(ACC_W-1).
  - Set sat=1 when a clamp occurs; sat SHALL remain set until the next start.
REQ-022 Each accepted product SHALL decrement the remaining counter by 1.
  - Accepting a product with remaining=1 SHALL move the state to HOLD on the next edge.
  - res_valid SHALL therefore be 1 exactly one cycle after the final accept.
REQ-023 In HOLD, res_valid SHALL be 1.
  - res and sat SHALL be stable.
  - prod_ready SHALL be 0.
REQ-024 In HOLD, when res_ready=1, the state SHALL return to IDLE and res_valid SHALL be 0 on the next cycle.
REQ-025 A start asserted in ACC or HOLD SHALL be ignored, including in the same cycle as the final res handshake.
REQ-026 res SHALL always equal the current accumulator value.
REQ-027 busy SHALL be 1 in ACC and in HOLD.

Reset
REQ-028 When rst_n=0 at a rising clk edge, the following SHALL take effect on that edge:
  - state SHALL be IDLE;
  - the accumulator, res, the remaining counter and sat SHALL be 0;
  - res_valid, prod_ready and busy SHALL be 0.
REQ-029 A reset during ACC or HOLD SHALL abort the run.
  - No res_valid SHALL be produced for the aborted run.
  - Products offered during reset SHALL be discarded.

Verification
REQ-030 Basic run: start with len=3, then products 100, -50, 7 accepted back to back -> res=57 and sat=0, with res_valid rising one cycle after the third accept.
REQ-031 Saturation: with ACC_W=16, start with len=2, products 32767 then 1 -> res=32767 (0x7FFF) and sat=1; a second run with len=1, product -5 -> res=-5 and sat=0.
REQ-032 Zero length: start with len=0 -> res_valid=1 and res=0 on the cycle after start, and prod_ready never asserts.
REQ-033 Gaps and backpressure:
  - Stimulus: len=2, products 3 and 4 with prod_valid low for 2 cycles between them, res_ready held low for 5 cycles in HOLD, start pulsed during HOLD.
  - Response: res=7 stays stable with res_valid=1 for 5 cycles, the start pulse is ignored, and the state returns to IDLE one cycle after res_ready=1.
REQ-034 Reset mid-run: start with len=4, accept 2 products, then rst_n=0 for 1 cycle -> next cycle res=0, busy=0, prod_ready=0, and res_valid stays 0.

Source files
------------

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Accumulates a run of signed 16-bit products from an upstream 8x8 Booth
// multiplier into a saturating signed accumulator. A run is opened by a
// single-cycle start pulse, which also captures the run length. Products are
// accepted with a valid/ready handshake. After the last product the result is
// held with res_valid until the downstream side takes it.
//
// Ports
//   clk         rising-edge clock for all state
//   rst_n       synchronous active-low reset
//   start       request to begin a run (looked at only in IDLE)
//   len         number of products in the run, captured with start
//   prod        signed two's-complement product
//   prod_valid  prod is valid this cycle
//   prod_ready  block accepts prod this cycle (ACC state only)
//   res         signed accumulated result (always the accumulator value)
//   res_valid   res is valid and held (HOLD state)
//   res_ready   downstream consumes res this cycle
//   sat         sticky saturation flag for the current or last run
//   busy        high in any state other than IDLE
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             sat,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Sign-extension width needed to bring prod up to ACC_W+1 bits.
    localparam int EXT_W = ACC_W + 1 - 16;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [LEN_W-1:0] rem_q,   rem_d;
    logic             sat_q,   sat_d;

    logic [ACC_W:0]   sum;
    logic             overflow;

    // One guard bit above the accumulator: overflow shows up as the top two
    // bits disagreeing, and the guard bit gives the true sign of the sum.
    assign sum      = {acc_q[ACC_W-1], acc_q} + {{EXT_W{prod[15]}}, prod};
    assign overflow = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        sat_d   = sat_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = len;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    state_d = (len == '0) ? HOLD : ACC;
                end
            end

            ACC: begin
                // prod_ready is implied by being in ACC.
                if (prod_valid) begin
                    if (overflow) begin
                        acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                // start is deliberately not looked at here, even on the
                // handshake cycle.
                if (res_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            sat_q   <= sat_d;
        end
    end

    // All outputs decode straight from flops, so they are glitch-free.
    assign prod_ready = (state_q == ACC);
    assign res_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign res        = acc_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    localparam int ACC_W = 16;
    localparam int LEN_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [15:0]      prod;
    logic             prod_valid;
    logic             prod_ready;
    logic [ACC_W-1:0] res;
    logic             res_valid;
    logic             res_ready;
    logic             sat;
    logic             busy;

    int checks;
    int failures;

    product_accumulator #(
        .ACC_W(ACC_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .res        (res),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .sat        (sat),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (res !== 16'd0) begin
            failures++;
            $display("FAIL reset_res actual=%h required=0000", res);
        end
        checks++;
        if ({res_valid, prod_ready, busy, sat} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags actual=%b required=0000", {res_valid, prod_ready, busy, sat});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy actual=%b required=0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, prod_ready, res_valid} !== 3'b110) begin
            failures++;
            $display("FAIL basic_enter_acc actual=%b required=110", {busy, prod_ready, res_valid});
        end
        prod_valid = 1'b1; prod = 16'd100;
        tick();
        prod = 16'hFFCE;                // -50
        tick();
        checks++;
        if (res !== 16'd50) begin
            failures++;
            $display("FAIL basic_partial actual=%0d required=50", $signed(res));
        end
        prod = 16'd7;
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid actual=%b required=0", res_valid);
        end
        tick();                         // third accept
        prod_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res !== 16'd57 || sat !== 1'b0) begin
            failures++;
            $display("FAIL basic_result actual=v%b res=%0d sat=%b required=v1 res=57 sat=0",
                     res_valid, $signed(res), sat);
        end
        checks++;
        if (prod_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold_ready actual=%b required=0", prod_ready);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res !== 16'd57) begin
            failures++;
            $display("FAIL basic_return_idle actual=v%b busy=%b res=%0d required=v0 busy=0 res=57",
                     res_valid, busy, $signed(res));
        end
        $display("test_basic done res=%0d", $signed(res));
    endtask

    task automatic test_saturation();
        // Positive clamp
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0; prod_valid = 1'b1; prod = 16'h7FFF;
        tick();
        prod = 16'd1;
        tick();
        prod_valid = 1'b0;
        checks++;
        if (res !== 16'h7FFF || sat !== 1'b1 || res_valid !== 1'b1) begin
            failures++;
            $display("FAIL sat_pos actual=res=%h sat=%b v=%b required=res=7fff sat=1 v=1", res, sat, res_valid);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        checks++;
        if (sat !== 1'b1 || res !== 16'h7FFF) begin
            failures++;
            $display("FAIL sat_sticky_idle actual=sat=%b res=%h required=sat=1 res=7fff", sat, res);
        end
        // Second run clears sat
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        checks++;
        if (sat !== 1'b0 || res !== 16'd0) begin
            failures++;
            $display("FAIL sat_clear_on_start actual=sat=%b res=%h required=sat=0 res=0000", sat, res);
        end
        prod_valid = 1'b1; prod = 16'hFFFB;   // -5
        tick();
        prod_valid = 1'b0;
        checks++;
        if (res !== 16'hFFFB || sat !== 1'b0 || res_valid !== 1'b1) begin
            failures++;
            $display("FAIL sat_second_run actual=res=%0d sat=%b v=%b required=res=-5 sat=0 v=1",
                     $signed(res), sat, res_valid);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        // Negative clamp: -32768 + -1
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0; prod_valid = 1'b1; prod = 16'h8000;
        tick();
        prod = 16'hFFFF;
        tick();
        prod_valid = 1'b0;
        checks++;
        if (res !== 16'h8000 || sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_neg actual=res=%h sat=%b required=res=8000 sat=1", res, sat);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        $display("test_saturation done");
    endtask

    task automatic test_zero_len();
        start = 1'b1; len = 4'd0;
        prod_valid = 1'b1; prod = 16'd9;
        checks++;
        if (prod_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_ready_idle actual=%b required=0", prod_ready);
        end
        tick();
        start = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res !== 16'd0 || prod_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_hold actual=v=%b res=%h rdy=%b required=v=1 res=0000 rdy=0",
                     res_valid, res, prod_ready);
        end
        tick();
        checks++;
        if (prod_ready !== 1'b0 || res !== 16'd0) begin
            failures++;
            $display("FAIL zero_no_accept actual=rdy=%b res=%h required=rdy=0 res=0000", prod_ready, res);
        end
        prod_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_idle actual=%b required=0", busy);
        end
        $display("test_zero_len done");
    endtask

    task automatic test_back_to_back();
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0; prod_valid = 1'b1; prod = 16'd3;
        tick();
        prod_valid = 1'b0; prod = 16'd100;    // value must be ignored while invalid
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (res !== 16'd3 || prod_ready !== 1'b1 || res_valid !== 1'b0) begin
                failures++;
                $display("FAIL gap_hold[%0d] actual=res=%0d rdy=%b v=%b required=res=3 rdy=1 v=0",
                         i, $signed(res), prod_ready, res_valid);
            end
        end
        prod_valid = 1'b1; prod = 16'd4;
        tick();
        prod_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); len = 4'd5;     // stray start in HOLD
            checks++;
            if (res !== 16'd7 || res_valid !== 1'b1 || prod_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure[%0d] actual=res=%0d v=%b rdy=%b required=res=7 v=1 rdy=0",
                         i, $signed(res), res_valid, prod_ready);
            end
            tick();
        end
        // start together with the handshake must also be ignored
        start = 1'b1; res_ready = 1'b1;
        checks++;
        if (res !== 16'd7 || res_valid !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_last actual=res=%0d v=%b required=res=7 v=1", $signed(res), res_valid);
        end
        tick();
        start = 1'b0; res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res !== 16'd7) begin
            failures++;
            $display("FAIL handshake_idle actual=busy=%b v=%b res=%0d required=busy=0 v=0 res=7",
                     busy, res_valid, $signed(res));
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored actual=busy=%b required=0", busy);
        end
        $display("test_back_to_back done res=%0d", $signed(res));
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0; prod_valid = 1'b1; prod = 16'd10;
        tick();
        prod = 16'd20;
        tick();
        checks++;
        if (res !== 16'd30 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre actual=res=%0d busy=%b required=res=30 busy=1", $signed(res), busy);
        end
        rst_n = 1'b0; prod = 16'd5;            // product offered during reset
        tick();
        rst_n = 1'b1;
        checks++;
        if (res !== 16'd0 || busy !== 1'b0 || prod_ready !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset actual=res=%0d busy=%b rdy=%b v=%b required=res=0 busy=0 rdy=0 v=0",
                     $signed(res), busy, prod_ready, res_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b0 || busy !== 1'b0 || res !== 16'd0) begin
                failures++;
                $display("FAIL midrun_after[%0d] actual=v=%b busy=%b res=%0d required=v=0 busy=0 res=0",
                         i, res_valid, busy, $signed(res));
            end
        end
        prod_valid = 1'b0;
        $display("test_reset_mid_run done");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        len = '0;
        prod = '0;
        prod_valid = 1'b0;
        res_ready = 1'b0;

        test_reset();
        test_basic();
        test_saturation();
        test_zero_len();
        test_back_to_back();
        test_reset_mid_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
